logic_exec_stage: RTL

LOGIC_EXEC_STAGE -- requirements
Module: logic_exec_stage

---
 rtl/logic_exec_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/logic_exec_stage.sv
// Single-cycle bitwise logic execute stage (AND/OR/XOR/ANDN) with an output register and one-entry skid buffer.
// Optional transfer counter on port perf_count when LOGIC_EXEC_STAGE_PERF_CNT_EN is defined.
module logic_exec_stage #(
    parameter int OPERANDSIZE = 64,
    parameter int TAGSIZE     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [OPERANDSIZE-1:0] in_a,
    input  logic [OPERANDSIZE-1:0] in_b,
    input  logic [TAGSIZE-1:0]     in_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPERANDSIZE-1:0] out_result,
    output logic [TAGSIZE-1:0]     out_rd,
    output logic                   out_zero
`ifdef LOGIC_EXEC_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]            perf_count
`endif
);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_ANDN = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_e;

    state_e state, next_state;

    logic                   in_ready_q;
    logic                   accept;
    logic                   xfer;
    logic [OPERANDSIZE-1:0] new_result;
    logic                   new_zero;
    logic                   load_main_in;
    logic                   load_main_skid;
    logic                   load_skid;

    logic [OPERANDSIZE-1:0] main_result, skid_result;
    logic [TAGSIZE-1:0]     main_rd, skid_rd;
    logic                   main_zero, skid_zero;

    assign in_ready   = in_ready_q;
    assign accept     = in_valid && in_ready_q;
    assign xfer       = out_valid && out_ready;
    assign out_result = main_result;
    assign out_rd     = main_rd;
    assign out_zero   = main_zero;

    always_comb begin
        unique case (op_e'(in_op))
            OP_AND:  new_result = in_a & in_b;
            OP_OR:   new_result = in_a | in_b;
            OP_XOR:  new_result = in_a ^ in_b;
            OP_ANDN: new_result = in_a & ~in_b;
            default: new_result = '0;
        endcase
    end

    // Zero flag is computed once at load time and travels with the data through skid and main.
    assign new_zero = (new_result == '0);

    // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            EMPTY: if (accept) next_state = ONE;
            ONE: begin
                if (accept && !xfer)      next_state = FULL;
                else if (!accept && xfer) next_state = EMPTY;
            end
            FULL:    if (xfer) next_state = ONE;
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin
        out_valid      = (state != EMPTY);
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: load_main_in = accept;
            ONE: begin
                load_main_in = accept && xfer;
                load_skid    = accept && !xfer;
            end
            FULL:    load_main_skid = xfer;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state != FULL);
        end
    end

    // NOTE: datapath registers are reset too, because the reset values of out_result/out_rd/out_zero are visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_result <= '0;
            main_rd     <= '0;
            main_zero   <= 1'b1;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_zero   <= 1'b1;
        end else begin
            if (load_main_in) begin
                main_result <= new_result;
                main_rd     <= in_rd;
                main_zero   <= new_zero;
            end else if (load_main_skid) begin
                main_result <= skid_result;
                main_rd     <= skid_rd;
                main_zero   <= skid_zero;
            end
            if (load_skid) begin
                skid_result <= new_result;
                skid_rd     <= in_rd;
                skid_zero   <= new_zero;
            end
        end
    end

`ifdef LOGIC_EXEC_STAGE_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (xfer && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_count = perf_cnt;
`endif

endmodule
